// File: rtl/seq_adder.sv
// rtl/seq_adder.sv - chunk-serial adder/subtractor with valid/ready handshakes
module seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              cr_q, cr_d;
    logic              sub_q, sub_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    int                lsb;
    logic [CHUNK-1:0]  ca;
    logic [CHUNK-1:0]  cb;
    logic [CHUNK:0]    chunk_res;
    logic              msb_cin;
    logic              last_chunk;

    // Select the current chunk of the latched operands and add it with the carry register.
    always_comb begin
        lsb        = int'(k_q) * CHUNK;
        ca         = a_q[lsb +: CHUNK];
        cb         = b_q[lsb +: CHUNK];
        chunk_res  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, cr_q};
        // Carry into the chunk MSB recovered from the MSB sum bit; on the last chunk this is the carry into bit WIDTH-1.
        msb_cin    = ca[CHUNK-1] ^ cb[CHUNK-1] ^ chunk_res[CHUNK-1];
        last_chunk = (k_q == KW'(N - 1));
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        cr_d    = cr_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1 - cin, so B is inverted and the borrow-in becomes an inverted carry-in.
                    a_d     = A;
                    b_d     = B ^ {WIDTH{sub}};
                    cr_d    = cin ^ sub;
                    sub_d   = sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[lsb +: CHUNK] = chunk_res[CHUNK-1:0];
                cr_d                = chunk_res[CHUNK];
                if (last_chunk) begin
                    carry_d = chunk_res[CHUNK] ^ sub_q;
                    ovf_d   = msb_cin ^ chunk_res[CHUNK];
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Register all state and outputs; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cr_q        <= 1'b0;
            sub_q       <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cr_q        <= cr_d;
            sub_q       <= sub_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
